// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-ROM program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
    CHECK,
    DONE,
    ERR
  } state_e;

  localparam int unsigned DEF_D     = 10;
  localparam int unsigned DEF_W     = 9;
  localparam int unsigned MAX_WORDS = 512;

endpackage

// File: rtl/prog_loader.sv
// Streams a length-framed, XOR-checksummed program into the instruction ROM
// write port and keeps the core in reset until the image is verified.
module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned D = DEF_D,
  parameter int unsigned W = DEF_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         wr_en,
  output logic [D-1:0] wr_addr,
  output logic [W-1:0] wr_data,
  output logic         core_hold,
  output logic         load_done,
  output logic         load_err
);

  state_e       state_q, state_d;
  logic [D-1:0] addr_q, addr_d;
  logic [8:0]   remaining_q, remaining_d;
  logic [W-1:0] acc_q, acc_d;

  logic         in_ready_q, in_ready_d;
  logic         wr_en_q, wr_en_d;
  logic [D-1:0] wr_addr_q, wr_addr_d;
  logic [W-1:0] wr_data_q, wr_data_d;
  logic         core_hold_q, core_hold_d;
  logic         load_done_q, load_done_d;
  logic         load_err_q, load_err_d;

  logic         beat;

  assign beat = in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    acc_d       = acc_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    case (state_q)
      IDLE: begin
        if (start) state_d = HDR;
      end
      HDR: begin
        if (beat) begin
          remaining_d = 9'(in_data);
          addr_d      = '0;
          acc_d       = '0;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        if (beat) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = in_data;
          acc_d     = acc_q ^ in_data;
          addr_d    = addr_q + D'(1);
          if (remaining_q == '0) begin
            state_d = CHECK;
          end else begin
            remaining_d = remaining_q - 9'd1;
          end
        end
      end
      CHECK: begin
        if (beat) state_d = (in_data == acc_q) ? DONE : ERR;
      end
      DONE, ERR: begin
        if (start) state_d = HDR;
      end
      default: state_d = IDLE;
    endcase

    // Status outputs are registered from the next state so they change on the
    // same edge that accepts the deciding beat.
    in_ready_d  = (state_d == HDR) || (state_d == LOAD) || (state_d == CHECK);
    core_hold_d = (state_d != DONE);
    load_done_d = (state_d == DONE);
    load_err_d  = (state_d == ERR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      core_hold_q <= 1'b1;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      core_hold_q <= core_hold_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign core_hold = core_hold_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomised frame-level bench for prog_loader: a queue of expected writes
// (due cycle, address, data) plus per-frame flag expectations.
module tb_prog_loader;

  localparam int D = 10;
  localparam int W = 9;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         wr_en;
  logic [D-1:0] wr_addr;
  logic [W-1:0] wr_data;
  logic         core_hold;
  logic         load_done;
  logic         load_err;

  always #5 clk = ~clk;

  prog_loader #(.D(D), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .core_hold (core_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  typedef struct {
    int due;
    int addr;
    int data;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  int          ncyc   = 0;
  wr_t         expq[$];
  logic [8:0]  pl[$];
  logic [8:0]  vec [4] = '{9'h1A5, 9'h003, 9'h100, 9'h0FF};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, ncyc);
    end
  endtask

  // Advance to the next falling edge and check the write port against the
  // expected-write queue for this cycle.
  task automatic tick();
    bit due;
    @(negedge clk);
    ncyc++;
    due = (expq.size() > 0) && (expq[0].due == ncyc);
    check("wr_en", 32'(wr_en), 32'(due));
    if (due) begin
      check("wr_addr", 32'(wr_addr), 32'(expq[0].addr));
      check("wr_data", 32'(wr_data), 32'(expq[0].data));
      void'(expq.pop_front());
    end
  endtask

  task automatic send_word(input logic [8:0] w, input int gap, input int paddr, input bit pulse_start);
    bit rdy;
    int guard;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = w;
    guard    = 0;
    do begin
      rdy   = in_ready;
      start = pulse_start;
      if (rdy && paddr >= 0) expq.push_back('{ncyc + 1, paddr, int'(w)});
      tick();
      start = 1'b0;
      guard++;
    end while (!rdy && guard < 20);
    if (!rdy) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd0);
    check({tag, "_wr_en"},     32'(wr_en),     32'd0);
    check({tag, "_wr_addr"},   32'(wr_addr),   32'd0);
    check({tag, "_wr_data"},   32'(wr_data),   32'd0);
    check({tag, "_core_hold"}, 32'(core_hold), 32'd1);
    check({tag, "_load_done"}, 32'(load_done), 32'd0);
    check({tag, "_load_err"},  32'(load_err),  32'd0);
  endtask

  // mode 0: fixed four-word vector, 1: random words, 2: data = address
  task automatic run_frame(input int n, input int mode, input bit bad, input bit gaps,
                           input int start_at, input int abort_after);
    logic [8:0] x;
    logic [8:0] w;
    int         t0;
    int         gap;
    pl.delete();
    x = '0;
    for (int i = 0; i < n; i++) begin
      if (mode == 0)      w = vec[i];
      else if (mode == 1) w = 9'($urandom_range(0, 511));
      else                w = 9'(i);
      pl.push_back(w);
      x = x ^ w;
    end
    if (bad) x = x ^ 9'h001;

    in_valid = 1'b0;
    start    = 1'b1;
    t0       = ncyc;
    tick();
    start = 1'b0;
    check("hdr_in_ready",  32'(in_ready),  32'd1);
    check("hdr_core_hold", 32'(core_hold), 32'd1);
    check("hdr_load_done", 32'(load_done), 32'd0);
    check("hdr_load_err",  32'(load_err),  32'd0);

    send_word(9'(n - 1), 0, -1, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (i == abort_after) begin
        reset = 1'b0;
        #1;
        check_reset_outputs("abort");
        expq.delete();
        in_valid = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        check_reset_outputs("post_abort");
        return;
      end
      gap = (gaps && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : 0;
      send_word(pl[i], gap, i, i == start_at);
    end
    gap = gaps ? int'($urandom_range(1, 3)) : 0;
    send_word(x, gap, -1, 1'b0);
    in_valid = 1'b0;

    check("load_done", 32'(load_done), 32'(!bad));
    check("core_hold", 32'(core_hold), 32'(bad));
    check("load_err",  32'(load_err),  32'(bad));
    check("idle_ready", 32'(in_ready), 32'd0);
    if (!gaps) check("frame_time", 32'(ncyc - t0), 32'(n + 3));
    repeat (2) tick();
    check("writes_pending", 32'(expq.size()), 32'd0);
    check("flags_hold", 32'(load_done), 32'(!bad));
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) tick();
    check_reset_outputs("reset");
    reset = 1'b1;
    tick();
    check_reset_outputs("idle");

    run_frame(4, 0, 1'b0, 1'b0, -1, -1);   // clean load
    run_frame(4, 0, 1'b1, 1'b0, -1, -1);   // bad checksum, restarted from DONE
    repeat (3) run_frame(4, 0, 1'b0, 1'b1, -1, -1);  // gaps, restarted from ERR
    run_frame(4, 0, 1'b0, 1'b0, 1, -1);    // start pulsed during LOAD
    run_frame(4, 0, 1'b0, 1'b0, -1, 2);    // reset after two payload beats
    run_frame(4, 0, 1'b0, 1'b0, -1, -1);
    for (int k = 0; k < 6; k++) begin
      run_frame(int'($urandom_range(1, 40)), 1, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), -1, -1);
    end
    run_frame(512, 2, 1'b0, 1'b0, -1, -1); // max length

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got 0x0 expected 0x1");
    $fatal(1, "timeout");
  end

endmodule
